// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage pipelined 32-bit subtractor (a - b - bw_in) with borrow, overflow and valid/ready on both sides
module sub32_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        bw_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] diff_out,
  output logic        bw_out,
  output logic        ovf_out,
  output logic        out_valid,
  input  logic        out_ready
);
  logic        s1_valid;
  logic        bm;
  logic [15:0] lo;
  logic [15:0] ah;
  logic [15:0] bh;
  logic [16:0] lo_w;
  logic [16:0] hi_w;
  logic        s2_free;
  logic        accept;
  logic        s2_load;
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;
  assign lo_w = {1'b0, a_in[15:0]} - {1'b0, b_in[15:0]} - {16'b0, bw_in};
  assign hi_w = {1'b0, ah} - {1'b0, bh} - {16'b0, bm};
  // ah[15]/bh[15] are the operand sign bits, so no separate sign registers are kept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      bm        <= 1'b0;
      lo        <= '0;
      ah        <= '0;
      bh        <= '0;
      out_valid <= 1'b0;
      diff_out  <= '0;
      bw_out    <= 1'b0;
      ovf_out   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        lo       <= lo_w[15:0];
        bm       <= lo_w[16];
        ah       <= a_in[31:16];
        bh       <= b_in[31:16];
      end else if (s2_load)
        s1_valid <= 1'b0;
      if (s2_load) begin
        out_valid <= 1'b1;
        diff_out  <= {hi_w[15:0], lo};
        bw_out    <= hi_w[16];
        ovf_out   <= (ah[15] != bh[15]) && (hi_w[15] != ah[15]);
      end else if (out_ready)
        out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: directed and random checks of sub32_pipe against a whole-word reference model via an in-order scoreboard
module tb_sub32_pipe;
  logic        clk;
  logic        rst_n;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        bw_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] diff_out;
  logic        bw_out;
  logic        ovf_out;
  logic        out_valid;
  logic        out_ready;

  int passed = 0;
  int total = 0;
  int fails = 0;
  logic [34:0] sb[$];

  sub32_pipe dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .bw_in(bw_in),
    .in_valid(in_valid), .in_ready(in_ready), .diff_out(diff_out),
    .bw_out(bw_out), .ovf_out(ovf_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bw);
    logic [32:0] r;
    r = {1'b0, a} - {1'b0, b} - {32'b0, bw};
    return {(a[31] != b[31]) && (r[31] != a[31]), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; samples, then advances one cycle.
  task automatic tick();
    logic [34:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_result", {29'b0, ovf_out, bw_out, diff_out}, 64'hDEAD);
      else begin
        e = sb.pop_front();
        chk("result", {29'b0, ovf_out, bw_out, diff_out}, {29'b0, e});
      end
    end
    if (in_valid && in_ready) sb.push_back(model(a_in, b_in, bw_in));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic bw,
                    input logic [31:0] ed, input logic eb, input logic eo);
    a_in = a; b_in = b; bw_in = bw; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("op_in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    #1 chk("op_s1_only", {63'b0, out_valid}, 64'd0);
    tick();
    #1 chk("op_out_valid", {63'b0, out_valid}, 64'd1);
    chk("op_const", {29'b0, ovf_out, bw_out, diff_out}, {29'b0, eo, eb, ed});
    tick();
    #1 chk("op_no_dup", {63'b0, out_valid}, 64'd0);
  endtask

  logic [31:0] vals [4];
  int k;
  int issued;
  int cyc;

  initial begin
    rst_n = 1'b0; a_in = '0; b_in = '0; bw_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("reset_outputs", {29'b0, out_valid, bw_out, ovf_out, diff_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);

    op(32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0);
    op(32'd5, 32'd3, 1'b1, 32'h00000001, 1'b0, 1'b0);
    op(32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    op(32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    op(32'h00010000, 32'd1, 1'b0, 32'h0000FFFF, 1'b0, 1'b0);
    op(32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);

    // backpressure: stall output for five cycles with operands pending
    vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30; vals[3] = 32'd40;
    k = 0; b_in = 32'd1; bw_in = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a_in = vals[k];
      #1;
      if (c >= 2) begin
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("bp_hold", {31'b0, out_valid, diff_out}, {31'b0, 1'b1, 32'd9});
      end
      if (in_ready) k++;
      tick();
    end
    chk("bp_accepts", 64'(k), 64'd2);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = (k < 4);
      a_in = vals[k < 4 ? k : 3];
      #1 chk("bp_stream", {31'b0, out_valid, diff_out}, {31'b0, 1'b1, vals[j] - 32'd1});
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    #1 chk("bp_drained", {31'b0, out_valid, 32'(sb.size())}, 64'd0);

    // random streaming with random handshakes
    issued = 0; cyc = 0;
    while (issued < 1000 && cyc < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a_in = $urandom; b_in = $urandom; bw_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) b_in = a_in;
      #1;
      if (in_valid && in_ready) issued++;
      #0 tick();
      cyc++;
    end
    chk("stream_issued", 64'(issued), 64'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // reset with two operations in flight
    out_ready = 1'b0; in_valid = 1'b1; a_in = 32'h55; b_in = 32'h11; bw_in = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    #1 chk("rst_full", {62'b0, out_valid, in_ready}, {62'b0, 2'b10});
    #1 rst_n = 1'b0;
    #1 chk("rst_async", {29'b0, out_valid, bw_out, ovf_out, diff_out}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    #1 chk("rst_no_stale", {63'b0, out_valid}, 64'd0);
    op(32'd100, 32'd58, 1'b0, 32'd42, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
